// File: rtl/dcqcn_pkg.sv
// Shared types, constants and the per-event context update for the DCQCN
// reaction-point rate engine.
package dcqcn_pkg;

  localparam int NUM_FLOWS   = 64;
  localparam int FLOW_ID_W   = $clog2(NUM_FLOWS);
  localparam int RATE_W      = 32;
  localparam int ALPHA_W     = 10;
  localparam int DCQCN_G     = 4;
  localparam int RPG_THRESH  = 5;
  localparam int RAI_RATE    = 40;
  localparam int RHAI_RATE   = 400;
  localparam int LINE_RATE   = 100000;
  localparam int MIN_RATE    = 10;
  localparam int BYTE_THRESH = 1024;
  localparam int BYTES_W     = 16;
  localparam int STAGE_W     = 8;

  localparam logic [RATE_W-1:0]  LINE_RATE_V = RATE_W'(LINE_RATE);
  localparam logic [RATE_W-1:0]  MIN_RATE_V  = RATE_W'(MIN_RATE);
  localparam logic [ALPHA_W-1:0] ALPHA_MAX   = '1;
  // Additive alpha term g * 1.0, carried one bit wider so the sum can saturate.
  localparam logic [ALPHA_W:0]   ALPHA_INC   = (ALPHA_W+1)'(1 << (ALPHA_W - DCQCN_G));

  typedef enum logic [1:0] {
    EVT_CNP         = 2'd0,
    EVT_RP_TIMER    = 2'd1,
    EVT_ALPHA_TIMER = 2'd2,
    EVT_BYTES       = 2'd3
  } evt_type_e;

  typedef struct packed {
    logic [RATE_W-1:0]  rate;
    logic [RATE_W-1:0]  target;
    logic [ALPHA_W-1:0] alpha;
    logic [STAGE_W-1:0] t_stage;
    logic [STAGE_W-1:0] b_stage;
    logic [BYTES_W-1:0] byte_cnt;
    logic               cnp_seen;
  } flow_ctx_t;

  localparam int CTX_W = $bits(flow_ctx_t);

  // Context every flow starts from after the init sweep.
  function automatic flow_ctx_t ctx_default();
    flow_ctx_t c;
    c.rate     = LINE_RATE_V;
    c.target   = LINE_RATE_V;
    c.alpha    = ALPHA_MAX;
    c.t_stage  = '0;
    c.b_stage  = '0;
    c.byte_cnt = '0;
    c.cnp_seen = 1'b0;
    return c;
  endfunction

  // Rate increase on the already-advanced T/B stage counters.
  function automatic flow_ctx_t apply_increase(flow_ctx_t c);
    flow_ctx_t          r;
    logic [STAGE_W-1:0] s_max;
    logic [STAGE_W-1:0] s_min;
    logic [RATE_W-1:0]  step;
    logic [RATE_W:0]    tgt_sum;
    logic [RATE_W:0]    rate_sum;
    r     = c;
    s_max = (c.t_stage > c.b_stage) ? c.t_stage : c.b_stage;
    s_min = (c.t_stage > c.b_stage) ? c.b_stage : c.t_stage;
    if (s_max < STAGE_W'(RPG_THRESH)) begin
      step = '0;
    end else if (s_min < STAGE_W'(RPG_THRESH)) begin
      step = RATE_W'(RAI_RATE);
    end else begin
      step = RATE_W'(RHAI_RATE) * RATE_W'(s_min - STAGE_W'(RPG_THRESH - 1));
    end
    tgt_sum = {1'b0, c.target} + {1'b0, step};
    if (tgt_sum > {1'b0, LINE_RATE_V}) r.target = LINE_RATE_V;
    else                               r.target = tgt_sum[RATE_W-1:0];
    rate_sum = {1'b0, c.rate} + {1'b0, r.target};
    r.rate   = RATE_W'(rate_sum >> 1);
    return r;
  endfunction

  // Full context update for one event.
  function automatic flow_ctx_t dcqcn_compute(flow_ctx_t c, evt_type_e t,
                                              logic [BYTES_W-1:0] bytes);
    flow_ctx_t                 r;
    logic [RATE_W+ALPHA_W-1:0] prod;
    logic [RATE_W-1:0]         dec;
    logic [ALPHA_W:0]          a_next;
    logic [BYTES_W:0]          bsum;
    r      = c;
    prod   = '0;
    dec    = '0;
    a_next = '0;
    bsum   = '0;
    case (t)
      EVT_CNP: begin
        prod   = {{ALPHA_W{1'b0}}, c.rate} * {{RATE_W{1'b0}}, c.alpha};
        dec    = RATE_W'(prod >> (ALPHA_W + 1));
        r.target = c.rate;
        r.rate   = c.rate - dec;
        if (r.rate < MIN_RATE_V) r.rate = MIN_RATE_V;
        a_next = {1'b0, c.alpha} - {1'b0, c.alpha >> DCQCN_G} + ALPHA_INC;
        r.alpha    = (a_next > {1'b0, ALPHA_MAX}) ? ALPHA_MAX : a_next[ALPHA_W-1:0];
        r.t_stage  = '0;
        r.b_stage  = '0;
        r.byte_cnt = '0;
        r.cnp_seen = 1'b1;
      end
      EVT_RP_TIMER: begin
        if (c.t_stage != '1) r.t_stage = c.t_stage + 1'b1;
        r = apply_increase(r);
      end
      EVT_ALPHA_TIMER: begin
        // A CNP since the last alpha tick suppresses exactly one decay.
        if (c.cnp_seen) r.cnp_seen = 1'b0;
        else            r.alpha    = c.alpha - (c.alpha >> DCQCN_G);
      end
      default: begin
        bsum = {1'b0, c.byte_cnt} + {1'b0, bytes};
        if (bsum >= (BYTES_W+1)'(BYTE_THRESH)) begin
          bsum = bsum - (BYTES_W+1)'(BYTE_THRESH);
          if (c.b_stage != '1) r.b_stage = c.b_stage + 1'b1;
          r = apply_increase(r);
        end
        // Residue beyond one stage is kept but cannot wrap the counter.
        r.byte_cnt = bsum[BYTES_W] ? '1 : bsum[BYTES_W-1:0];
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dcqcn_rp_engine_if.sv
// Event-in / rate-update-out bundle between scheduler, engine and rate limiter.
interface dcqcn_rp_engine_if;
  import dcqcn_pkg::*;

  logic                 evt_valid;
  logic                 evt_ready;
  evt_type_e            evt_type;
  logic [FLOW_ID_W-1:0] evt_flow_id;
  logic [BYTES_W-1:0]   evt_bytes;
  logic                 upd_valid;
  logic [FLOW_ID_W-1:0] upd_flow_id;
  logic [RATE_W-1:0]    upd_rate;

  modport master (
    output evt_valid, evt_type, evt_flow_id, evt_bytes,
    input  evt_ready, upd_valid, upd_flow_id, upd_rate
  );

  modport slave (
    input  evt_valid, evt_type, evt_flow_id, evt_bytes,
    output evt_ready, upd_valid, upd_flow_id, upd_rate
  );
endinterface

// File: rtl/dcqcn_ctx_ram.sv
// Per-flow context store: one write port, one read port, registered read.
module dcqcn_ctx_ram import dcqcn_pkg::*; (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [FLOW_ID_W-1:0] waddr_i,
  input  flow_ctx_t            wdata_i,
  input  logic [FLOW_ID_W-1:0] raddr_i,
  output flow_ctx_t            rdata_o
);

  flow_ctx_t mem [NUM_FLOWS];

  // Write and read each cycle; a same-address read returns the old contents.
  // NOTE: the array has no reset so it maps onto RAM; the init sweep gives it
  // defined contents instead.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/dcqcn_rp_engine.sv
// Multi-flow DCQCN reaction-point engine: init sweep, then a two-stage
// read/compute-writeback pipeline with same-flow forwarding.
module dcqcn_rp_engine import dcqcn_pkg::*; (
  input  logic                    clk,
  input  logic                    rst_n,
  dcqcn_rp_engine_if.slave        evt_if,
  output logic                    init_done
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e               state_q;
  logic [FLOW_ID_W-1:0] init_cnt_q;

  logic                 s2_valid_q;
  evt_type_e            s2_type_q;
  logic [FLOW_ID_W-1:0] s2_flow_q;
  logic [BYTES_W-1:0]   s2_bytes_q;

  logic                 fwd_valid_q;
  logic [FLOW_ID_W-1:0] fwd_flow_q;
  flow_ctx_t            fwd_ctx_q;

  flow_ctx_t            ram_rdata;
  logic                 ram_we;
  logic [FLOW_ID_W-1:0] ram_waddr;
  flow_ctx_t            ram_wdata;
  flow_ctx_t            ctx_cur;
  flow_ctx_t            ctx_d;
  logic                 accept;

  assign accept = evt_if.evt_valid && (state_q == ST_RUN);

  // Init sweep FSM: one flow per cycle, then run forever.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else if (state_q == ST_INIT) begin
      init_cnt_q <= init_cnt_q + 1'b1;
      if (init_cnt_q == FLOW_ID_W'(NUM_FLOWS - 1)) state_q <= ST_RUN;
    end
  end

  // Stage 1: capture the accepted event while the RAM read is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_type_q  <= EVT_CNP;
      s2_flow_q  <= '0;
      s2_bytes_q <= '0;
    end else begin
      s2_valid_q <= accept;
      if (accept) begin
        s2_type_q  <= evt_if.evt_type;
        s2_flow_q  <= evt_if.evt_flow_id;
        s2_bytes_q <= evt_if.evt_bytes;
      end
    end
  end

  // Track the last write-back so a back-to-back event to the same flow sees it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid_q <= 1'b0;
      fwd_flow_q  <= '0;
    end else begin
      fwd_valid_q <= s2_valid_q;
      fwd_flow_q  <= s2_flow_q;
    end
  end

  // Forwarded context payload; qualified by fwd_valid_q so it needs no reset.
  always_ff @(posedge clk) begin
    fwd_ctx_q <= ctx_d;
  end

  // Stage 2: pick the freshest context and compute the update.
  // NOTE: combinational blocks use blocking assignments with a default first,
  // so no latch is inferred and later statements see earlier results.
  always_comb begin
    ctx_cur = ram_rdata;
    if (fwd_valid_q && (fwd_flow_q == s2_flow_q)) ctx_cur = fwd_ctx_q;
    ctx_d = dcqcn_compute(ctx_cur, s2_type_q, s2_bytes_q);
  end

  // RAM write port: default context during the sweep, write-back afterwards.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = s2_flow_q;
    ram_wdata = ctx_d;
    if (state_q == ST_INIT) begin
      ram_we    = 1'b1;
      ram_waddr = init_cnt_q;
      ram_wdata = ctx_default();
    end else if (s2_valid_q) begin
      ram_we    = 1'b1;
    end
  end

  dcqcn_ctx_ram u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (evt_if.evt_flow_id),
    .rdata_o (ram_rdata)
  );

  assign init_done          = (state_q == ST_RUN);
  assign evt_if.evt_ready   = (state_q == ST_RUN);
  assign evt_if.upd_valid   = s2_valid_q;
  assign evt_if.upd_flow_id = s2_valid_q ? s2_flow_q : '0;
  assign evt_if.upd_rate    = s2_valid_q ? ctx_d.rate : '0;

endmodule

// File: doc/dcqcn_rp_engine.md
# dcqcn_rp_engine

Multi-flow DCQCN reaction-point rate engine. It holds per-flow congestion context (rate, target rate, alpha, stage counters, byte counter) in an internal RAM. It accepts one congestion event per cycle (CNP, RP-timer tick, alpha-timer tick, bytes-sent) and updates that flow's context in a two-stage pipeline. It replaces single-flow combinational timeout logic in the user-defined congestion-control slot and sits between the event scheduler and the per-flow rate limiter.

## Interface
- NUM_FLOWS, 64: flows tracked; FLOW_ID_W = clog2(NUM_FLOWS)
- RATE_W, 32: rate width, Mbps units
- ALPHA_W, 10: alpha fraction width; 2^ALPHA_W-1 represents 1.0
- DCQCN_G, 4: alpha gain shift (g = 1/16)
- RPG_THRESH, 5: stage threshold for additive/hyper increase
- RAI_RATE, 40 / RHAI_RATE, 400: additive / hyper increase step
- LINE_RATE, 100000 / MIN_RATE, 10: rate clamp bounds
- BYTE_THRESH, 1024: bytes per byte-stage; BYTES_W, 16
- clk  in  1  clock; one clock domain
- rst_n  in  1  asynchronous, active-low reset
- evt_valid  in  1  event present
- evt_ready  out  1  engine accepts event (low during init sweep)
- evt_type  in  2  0 CNP, 1 RP timer, 2 alpha timer, 3 bytes sent
- evt_flow_id  in  FLOW_ID_W  target flow
- evt_bytes  in  BYTES_W  byte count (type 3 only)
- upd_valid  out  1  one-cycle strobe: context written
- upd_flow_id  out  FLOW_ID_W  flow updated
- upd_rate  out  RATE_W  new current rate
- init_done  out  1  init sweep finished

## Operation
- Init sweep after reset: write every flow rate=target=LINE_RATE, alpha=2^ALPHA_W-1, T=B=0, byte_cnt=0, cnp_seen=0. Takes one flow per cycle (NUM_FLOWS cycles). evt_ready=0 and init_done=0 until the sweep ends, then both go high and stay high.
- CNP: target=rate. rate -= (rate*alpha)>>(ALPHA_W+1), clamped to ≥MIN_RATE. alpha = alpha-(alpha>>G)+(1<<(ALPHA_W-G)), saturating at max. T=B=byte_cnt=0, cnp_seen=1.
- Alpha timer: if cnp_seen, clear cnp_seen and leave alpha unchanged. Otherwise alpha -= alpha>>G. Rate is unchanged, but upd still fires.
- RP timer: T++ (saturate 255), then increase.
- Bytes: byte_cnt += evt_bytes. If byte_cnt ≥ BYTE_THRESH: byte_cnt -= BYTE_THRESH, B++ (saturate 255), then increase. Otherwise no increase. At most one stage per event.
- Increase (on post-update T, B):
  - If max(T,B) < RPG_THRESH: fast recovery, target unchanged.
  - Else if min(T,B) < RPG_THRESH: target += RAI_RATE.
  - Else: target += RHAI_RATE*(min-RPG_THRESH+1).
  - Then clamp target ≤ LINE_RATE; rate = (rate+target)>>1, computed in RATE_W+1 bits.
- Intermediate products and sums are sized so they cannot overflow.

## Timing
- Accept on evt_valid & evt_ready.
- S1 (accept cycle): register event, issue RAM read.
- S2 (next cycle): compute, write back, assert upd_valid. Result latency is 1 cycle after accept; upd_valid is never back-pressured.
- Throughput is one event per cycle. Back-to-back events to the same flow forward S2's write-back context into the next compute (no stall). Two events on consecutive cycles therefore compound.
- Reset values: evt_ready=0, upd_valid=0, upd_flow_id=0, upd_rate=0, init_done=0.
- Reset mid-operation: in-flight events are dropped, the RAM is re-initialised by a new sweep, and no upd strobes occur during the sweep.
- evt_valid during init is ignored; the event is not held.

## Structure
- dcqcn_pkg holds:
  - evt_type enum
  - flow context struct (rate, target, alpha, T, B, byte_cnt, cnp_seen) and its width
  - the compute function
  - default constants
- Sub-module dcqcn_ctx_ram: simple dual-port, one read and one write port, 1-cycle read latency, NUM_FLOWS × context width, no reset of contents.

## Test plan
- Reset, wait NUM_FLOWS cycles: init_done rises on cycle 64, and an event on flow 0 is then accepted.
- CNP on fresh flow 3 → upd rate 50049, alpha stays 1023 (saturated), target 100000.
- Same cycle pair: CNP then RP timer back-to-back on flow 3 → second upd rate 75024, with T=1 verified by a subsequent read.
- Flow with rate=target=60000, T=4, B=5; RP timer → T=5, hyper: target 60400, upd rate 60200.
- Alpha timer twice after CNP: first leaves alpha 1023 and clears cnp_seen; second gives alpha 960.
- Bytes event of 1500 on fresh flow → byte_cnt 476, B=1, rate stays 100000. Assert reset mid-stream → no upd_valid until a new sweep completes.
